alu_seq_ctrl: RTL

Hardware control sequencer that replaces hand-driven control waveforms for register-register ALU instructions on the single-bus DataPath. The sequencer fetches from memory through MAR/MDR and loads IR. It decodes the opcode and ra/rb/rc fields, then drives the T0–T5 control step sequence. The register file size is parametrised, the sequencer inserts memory wait states, it supports single-step and continuous run modes, and it traps illegal opcodes. It sits between the memory interface and DataPath, driving every bus-select and register-enable strobe.

---
 rtl/alu_seq_pkg.sv | 34 +++
 rtl/alu_seq_ctrl_reg_sel_decoder.sv | 20 ++
 rtl/alu_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the register-register ALU control sequencer.
package alu_seq_pkg;

  localparam int OPW = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T0    = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_T3    = 3'd4,
    ST_T4    = 3'd5,
    ST_T5    = 3'd6,
    ST_FAULT = 3'd7
  } state_t;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;

  localparam logic [OPW-1:0] OP_LEGAL_MIN = OP_ADD;
  localparam logic [OPW-1:0] OP_LEGAL_MAX = OP_ROL;

  function automatic logic op_is_legal(input logic [OPW-1:0] op);
    return (op >= OP_LEGAL_MIN) && (op <= OP_LEGAL_MAX);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_reg_sel_decoder.sv
// Register-field to one-hot select decoder; all outputs low when disabled.
module reg_sel_decoder
  import alu_seq_pkg::*;
#(
  parameter  int RW       = 4,
  localparam int NUM_REGS = 2**RW
) (
  input  logic                i_en,
  input  logic [RW-1:0]       i_sel,
  output logic [NUM_REGS-1:0] o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign o_onehot[gi] = i_en && (i_sel == RW'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_seq_ctrl.sv
// Fetch/decode/execute control sequencer for register-register ALU instructions on the
// single-bus datapath. Outputs are a pure decode of state plus the fields latched in T3.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter  int RW       = 4,
  localparam int NUM_REGS = 2**RW
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [31:0]         ir,
  input  logic                fault_ack,
  output logic                PCout,
  output logic                Zlowout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic [OPW-1:0]      Operator,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  state_t         r_state;
  state_t         w_state_next;
  logic [OPW-1:0] r_op;
  logic [RW-1:0]  r_ra;
  logic [RW-1:0]  r_rc;
  logic           r_in_t1;

  logic [OPW-1:0] w_op;
  logic [RW-1:0]  w_ra;
  logic [RW-1:0]  w_rb;
  logic [RW-1:0]  w_rc;
  logic           w_rin_en;
  logic           w_rout_en;
  logic [RW-1:0]  w_rout_sel;

  assign w_op = ir[31:27];
  assign w_ra = ir[26 -: RW];
  assign w_rb = ir[26-RW -: RW];
  assign w_rc = ir[26-2*RW -: RW];

  // Low IR bits are immediate/unused for this instruction class.
  generate
    if (3*RW < 27) begin : g_spare
      logic w_unused_ir;
      assign w_unused_ir = ^ir[26-3*RW:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_ra    <= '0;
      r_rc    <= '0;
      r_in_t1 <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Marks T1 wait cycles so PC is only loaded on the first T1 cycle.
      r_in_t1 <= (r_state == ST_T1);
      if (r_state == ST_T3) begin
        r_op <= w_op;
        r_ra <= w_ra;
        r_rc <= w_rc;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    PCout        = 1'b0;
    Zlowout      = 1'b0;
    MDRout       = 1'b0;
    MARin        = 1'b0;
    Zin          = 1'b0;
    PCin         = 1'b0;
    MDRin        = 1'b0;
    IRin         = 1'b0;
    Yin          = 1'b0;
    IncPC        = 1'b0;
    Read         = 1'b0;
    Operator     = '0;
    w_rin_en     = 1'b0;
    w_rout_en    = 1'b0;
    w_rout_sel   = r_rc;
    done         = 1'b0;
    fault        = 1'b0;
    busy         = (r_state != ST_IDLE) && (r_state != ST_FAULT);

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_T0;
      end
      ST_T0: begin
        PCout        = 1'b1;
        MARin        = 1'b1;
        IncPC        = 1'b1;
        Zin          = 1'b1;
        w_state_next = ST_T1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = !r_in_t1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) w_state_next = ST_T2;
      end
      ST_T2: begin
        MDRout       = 1'b1;
        IRin         = 1'b1;
        w_state_next = ST_T3;
      end
      ST_T3: begin
        // rb comes straight from IR; op/ra/rc are latched on this edge.
        w_rout_en    = 1'b1;
        w_rout_sel   = w_rb;
        Yin          = 1'b1;
        w_state_next = op_is_legal(w_op) ? ST_T4 : ST_FAULT;
      end
      ST_T4: begin
        w_rout_en    = 1'b1;
        w_rout_sel   = r_rc;
        Operator     = r_op;
        Zin          = 1'b1;
        w_state_next = ST_T5;
      end
      ST_T5: begin
        Zlowout      = 1'b1;
        w_rin_en     = 1'b1;
        done         = 1'b1;
        w_state_next = run ? ST_T0 : ST_IDLE;
      end
      ST_FAULT: begin
        fault = 1'b1;
        if (fault_ack) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  reg_sel_decoder #(.RW(RW)) u_rin_dec (
    .i_en     (w_rin_en),
    .i_sel    (r_ra),
    .o_onehot (reg_in)
  );

  reg_sel_decoder #(.RW(RW)) u_rout_dec (
    .i_en     (w_rout_en),
    .i_sel    (w_rout_sel),
    .o_onehot (reg_out)
  );

endmodule
